// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types for the memory-stage controller: LC-3b word type,
// the memory controller state encoding and the full-word byte mask.
package mem_stage_ctrl_pkg;

    localparam int LC3B_WORD_W = 16;

    typedef logic [LC3B_WORD_W-1:0] lc3b_word;

    // Both byte lanes enabled; used for pointer reads and LDI/STI data accesses
    localparam logic [1:0] BE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        FINAL,
        HOLD
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller. Turns the EX/MEM control bits into a data-memory
// handshake (including the two-access LDI/STI sequence), stalls the pipeline
// until the access completes, and parks in HOLD when another stall source
// keeps the instruction in EX/MEM so it is never re-issued.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = LC3B_WORD_W,
    parameter int DATA_W = LC3B_WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              is_ldi_in,
    input  logic              is_sti_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [1:0]        byte_enable_in,
    input  logic              ext_stall,
    input  logic              dmem_resp,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_pipeline
);

    mem_ctrl_state_t   state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic isRead;
    logic isWrite;
    logic isIndirect;
    logic hasReq;
    logic stallRaw;

    // Decode the latched control bits; a simultaneous read and write is a read
    always_comb begin
        isRead     = mem_read_in;
        isWrite    = mem_write_in & ~mem_read_in;
        isIndirect = is_ldi_in | is_sti_in;
        hasReq     = mem_read_in | mem_write_in;
    end

    // Next-state, request generation and load-data bypass, all decoded from the state register
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        rdata_d          = rdata_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        mem_rdata        = rdata_q;
        stallRaw         = 1'b0;
        case (state_q)
            IDLE: begin
                if (hasReq) begin
                    stallRaw = 1'b1;
                    state_d  = isIndirect ? IND : FINAL;
                end
            end
            IND: begin
                dmem_read        = 1'b1;
                dmem_address     = addr_in;
                dmem_byte_enable = BE_WORD;
                stallRaw         = 1'b1;
                if (dmem_resp) begin
                    ptr_d   = dmem_rdata[ADDR_W-1:0];
                    state_d = FINAL;
                end
            end
            FINAL: begin
                dmem_address     = isIndirect ? ptr_q : addr_in;
                dmem_byte_enable = isIndirect ? BE_WORD : byte_enable_in;
                dmem_read        = isRead;
                dmem_write       = isWrite;
                if (isWrite) begin
                    dmem_wdata = wdata_in;
                end
                stallRaw = ~dmem_resp;
                if (dmem_resp) begin
                    mem_rdata = dmem_rdata;
                    rdata_d   = dmem_rdata;
                    state_d   = ext_stall ? HOLD : IDLE;
                end
            end
            HOLD: begin
                if (!ext_stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The IDLE-cycle stall is combinational on the inputs, so mask it while reset is held
    always_comb begin
        stall_pipeline = stallRaw & rst_n;
    end

    // State, pointer and load-result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Testbench for mem_stage_ctrl. The bench plays the pipeline (holding EX/MEM
// while stalled) and a data memory with scripted wait states. Expected memory
// accesses, latencies and load results are derived from instruction semantics
// and pushed to queues at issue time; a monitor pops and compares them.
module tb_mem_stage_ctrl;
    import mem_stage_ctrl_pkg::*;

    localparam int K_NOP = 0;
    localparam int K_LDR = 1;
    localparam int K_STR = 2;
    localparam int K_LDI = 3;
    localparam int K_STI = 4;
    localparam int K_RW  = 5;

    logic        clk;
    logic        rst_n;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        is_ldi_in;
    logic        is_sti_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic [1:0]  byte_enable_in;
    logic        ext_stall;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] mem_rdata;
    logic        stall_pipeline;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          w1;
        int          w2;
        bit          holdLong;
    } instr_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
    } acc_t;

    typedef struct {
        bit          isLoad;
        logic [15:0] data;
        int          lat;
    } ret_t;

    acc_t        expQ[$];
    ret_t        retQ[$];
    int          waitQ[$];
    logic [15:0] mem [logic [15:0]];

    int          checks = 0;
    int          errors = 0;
    bit          monEn = 0;
    logic [15:0] lastFinal = 16'h0;
    int          stallCnt = 0;
    bit          accActive = 0;
    int          curWait = 0;
    int          memWaited = 0;

    mem_stage_ctrl #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .is_ldi_in        (is_ldi_in),
        .is_sti_in        (is_sti_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .byte_enable_in   (byte_enable_in),
        .ext_stall        (ext_stall),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_rdata        (mem_rdata),
        .stall_pipeline   (stall_pipeline)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] memRead(input logic [15:0] a);
        logic [7:0] lo;
        if (mem.exists(a)) return mem[a];
        lo = a[7:0];
        return {lo, ~lo};
    endfunction

    function automatic instr_t mk(input int kind, input logic [15:0] addr, input logic [15:0] wdata,
                                  input logic [1:0] be, input int w1, input int w2, input bit holdLong);
        instr_t t;
        t.kind = kind; t.addr = addr; t.wdata = wdata; t.be = be;
        t.w1 = w1; t.w2 = w2; t.holdLong = holdLong;
        return t;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory response for the current cycle, driven just after the inputs settle
    task automatic memEval();
        #1;
        if (dmem_read || dmem_write) begin
            if (!accActive) begin
                curWait   = (waitQ.size() != 0) ? waitQ.pop_front() : 0;
                accActive = 1;
                memWaited = 0;
            end
            dmem_resp  = (memWaited >= curWait);
            dmem_rdata = dmem_resp ? memRead(dmem_address) : 16'($urandom);
        end else begin
            dmem_resp  = 1'($urandom_range(0, 1));
            dmem_rdata = 16'($urandom);
        end
    endtask

    // Memory bookkeeping at the sample point: count waits, commit writes
    task automatic memCommit();
        logic [15:0] old;
        if ((dmem_read || dmem_write) && accActive) begin
            if (dmem_resp) begin
                accActive = 0;
                if (dmem_write && !dmem_read) begin
                    old = memRead(dmem_address);
                    if (dmem_byte_enable[1]) old[15:8] = dmem_wdata[15:8];
                    if (dmem_byte_enable[0]) old[7:0]  = dmem_wdata[7:0];
                    mem[dmem_address] = old;
                end
            end else begin
                memWaited++;
            end
        end
    endtask

    // Place one instruction in EX/MEM, record its expected behaviour, and hold it until the pipeline advances
    task automatic applyStimulus(input instr_t in);
        bit          ind, wr, adv;
        logic [15:0] ptr;
        acc_t        a;
        ret_t        r;
        int          lat, cyc;
        ind = (in.kind == K_LDI) || (in.kind == K_STI);
        wr  = (in.kind == K_STR) || (in.kind == K_STI);
        mem_read_in    = (in.kind == K_LDR) || (in.kind == K_LDI) || (in.kind == K_RW);
        mem_write_in   = (in.kind == K_STR) || (in.kind == K_STI) || (in.kind == K_RW);
        is_ldi_in      = (in.kind == K_LDI);
        is_sti_in      = (in.kind == K_STI);
        addr_in        = in.addr;
        wdata_in       = in.wdata;
        byte_enable_in = in.be;
        lat = 0;
        ptr = 16'h0;
        if (in.kind != K_NOP) begin
            if (ind) begin
                ptr     = memRead(in.addr);
                a.wr    = 0;
                a.addr  = in.addr;
                a.wdata = 16'h0;
                a.be    = 2'b11;
                expQ.push_back(a);
                waitQ.push_back(in.w1);
            end
            a.wr    = wr;
            a.addr  = ind ? ptr : in.addr;
            a.be    = ind ? 2'b11 : in.be;
            a.wdata = wr ? in.wdata : 16'h0;
            expQ.push_back(a);
            waitQ.push_back(in.w2);
            r.isLoad = !wr;
            r.data   = memRead(a.addr);
            r.lat    = 1 + (ind ? 1 + in.w1 : 0) + in.w2;
            retQ.push_back(r);
            lat = r.lat;
        end
        cyc = 0;
        while (1) begin
            ext_stall = in.holdLong ? (cyc < lat + 3) : ($urandom_range(0, 3) == 0);
            memEval();
            @(negedge clk);
            adv = !stall_pipeline && !ext_stall;
            memCommit();
            @(posedge clk);
            #1;
            cyc++;
            if (adv) break;
            if (cyc > 60) begin
                checks++;
                errors++;
                $display("[TB] FAIL timeout: instruction kind %0d still held after %0d cycles", in.kind, cyc);
                break;
            end
        end
    endtask

    // Scoreboard monitor: compares every completed access, retirement latency and the load-result output
    always @(negedge clk) begin
        acc_t a;
        ret_t r;
        if (monEn) begin
            if (stall_pipeline) stallCnt++;
            if ((dmem_read || dmem_write) && dmem_resp) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL access: unexpected rd=%b wr=%b addr=%h, expected no access",
                             dmem_read, dmem_write, dmem_address);
                end else begin
                    a = expQ.pop_front();
                    checkOutput("access",
                        {dmem_read, dmem_write, dmem_byte_enable, dmem_address, (dmem_write ? dmem_wdata : 16'h0)},
                        {!a.wr, a.wr, a.be, a.addr, a.wdata});
                end
            end
            if ((dmem_read || dmem_write) && dmem_resp && !stall_pipeline) begin
                if (retQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL retire: completion with no instruction outstanding, expected none");
                end else begin
                    r = retQ.pop_front();
                    checkOutput("stall cycles", stallCnt, r.lat);
                    if (r.isLoad) checkOutput("load data", mem_rdata, r.data);
                    lastFinal = r.isLoad ? r.data : dmem_rdata;
                end
                stallCnt = 0;
            end else begin
                checkOutput("held rdata", mem_rdata, lastFinal);
            end
        end
    end

    // Main sequence: reset checks, directed cases, random traffic, reset in the middle of an LDI
    initial begin
        rst_n = 1'b0;
        mem_read_in = 1'b1; mem_write_in = 1'b0; is_ldi_in = 1'b1; is_sti_in = 1'b0;
        addr_in = 16'h1234; wdata_in = 16'h5678; byte_enable_in = 2'b11;
        ext_stall = 1'b0; dmem_resp = 1'b1; dmem_rdata = 16'hFFFF;
        for (int i = 0; i < 8; i++) mem[16'h4000 + 16'(2 * i)] = 16'h4000 + 16'(2 * ((i + 3) % 8));
        mem[16'h1000] = 16'hBEEF;
        mem[16'h2000] = 16'h3000;
        mem[16'h3000] = 16'h1234;
        #12;
        checkOutput("reset outputs",
            {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, mem_rdata, stall_pipeline}, 64'h0);
        mem_read_in = 1'b0; is_ldi_in = 1'b0; dmem_resp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        monEn = 1;

        applyStimulus(mk(K_LDR, 16'h1000, 16'h0000, 2'b11, 0, 2, 0));
        applyStimulus(mk(K_LDI, 16'h2000, 16'h0000, 2'b11, 0, 0, 0));
        mem[16'h2000] = 16'h4000;
        applyStimulus(mk(K_STI, 16'h2000, 16'h00AA, 2'b01, 0, 0, 0));
        applyStimulus(mk(K_STR, 16'h5001, 16'hCC33, 2'b10, 0, 1, 1));
        applyStimulus(mk(K_LDR, 16'h1000, 16'h0000, 2'b11, 0, 0, 0));
        applyStimulus(mk(K_STR, 16'h1002, 16'h9876, 2'b11, 0, 0, 0));
        applyStimulus(mk(K_LDR, 16'h1002, 16'h0000, 2'b01, 0, 0, 0));
        applyStimulus(mk(K_RW,  16'h1000, 16'h7777, 2'b11, 0, 1, 0));
        applyStimulus(mk(K_LDI, 16'h4000, 16'h0000, 2'b10, 2, 1, 1));

        for (int n = 0; n < 120; n++) begin
            applyStimulus(mk($urandom_range(0, 5), 16'h4000 + 16'(2 * $urandom_range(0, 7)), 16'($urandom),
                             2'($urandom_range(1, 3)), $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 7) == 0));
        end

        monEn = 0;
        checkOutput("queues drained", expQ.size() + retQ.size(), 0);

        mem_read_in = 1'b1; mem_write_in = 1'b0; is_ldi_in = 1'b1; is_sti_in = 1'b0;
        addr_in = 16'h2000; ext_stall = 1'b0; dmem_resp = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("LDI pointer request", {dmem_read, dmem_write, dmem_address, stall_pipeline},
                    {1'b1, 1'b0, 16'h2000, 1'b1});
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-op",
            {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable, mem_rdata, stall_pipeline}, 64'h0);
        mem_read_in = 1'b0; is_ldi_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("idle after reset", {dmem_read, dmem_write, stall_pipeline}, 64'h0);
        end
        mem_read_in = 1'b1; addr_in = 16'h1000; byte_enable_in = 2'b01;
        #1;
        checkOutput("new request stalls", {dmem_read, stall_pipeline}, {1'b0, 1'b1});
        @(posedge clk);
        #1;
        checkOutput("new request issued", {dmem_read, dmem_address, dmem_byte_enable}, {1'b1, 16'h1000, 2'b01});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
